// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array weight loader: FSM state type and
// default sizing constants.
package sa_pkg;

    localparam int N_WEIGHTS = 9;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sa_wl_delay.sv
// Fixed-latency delay line that aligns the read strobe and sequence index with
// the data returned by the weight memory. Synchronous clear empties it.
module sa_wl_delay
    import sa_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int IDX_W = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    logic [LAT-1:0]   r_vld;
    logic [IDX_W-1:0] r_idx [LAT];

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_idx = r_idx[LAT-1];

endmodule

// File: rtl/sa_weight_loader.sv
// Loads one kernel of N_WEIGHTS words from a fixed-latency weight memory into a
// register bank. Optional abort input is enabled by defining SA_WL_ABORT_EN.
module sa_weight_loader #(
    parameter int DATA_W    = sa_pkg::DATA_W,
    parameter int N_WEIGHTS = sa_pkg::N_WEIGHTS,
    parameter int MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
`ifdef SA_WL_ABORT_EN
    input  logic                          abort,
`endif
    output logic [sa_pkg::CNT_W-1:0]      cnt,
    output logic                          mem_re,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          w_valid,
    output logic [sa_pkg::CNT_W-1:0]      w_idx,
    output logic [N_WEIGHTS*DATA_W-1:0]   w_bank,
    output logic                          busy,
    output logic                          done,
    output logic                          weights_ready
);

    import sa_pkg::*;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [1:0]              r_dcnt, w_dcnt_nxt;
    logic                    r_ready, w_ready_nxt;
    logic                    w_abort;
    logic                    w_clr;
    logic                    w_mem_re;
    logic                    w_done;
    logic                    w_wvld;
    logic [CNT_W-1:0]        w_widx;
    logic [N_WEIGHTS*DATA_W-1:0] r_bank;

`ifdef SA_WL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dcnt_nxt  = r_dcnt;
        w_ready_nxt = r_ready;
        w_mem_re    = 1'b0;
        w_done      = 1'b0;
        w_clr       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start && !w_abort) begin
                    w_state_nxt = S_FETCH;
                    w_ready_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                w_mem_re = 1'b1;
                if (r_cnt == CNT_W'(N_WEIGHTS - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // Wait for the last read's data to come back before completing.
                if (r_dcnt == 2'(MEM_LAT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 2'd1;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Abort outranks everything once a load is in flight.
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_dcnt_nxt  = '0;
            w_ready_nxt = 1'b0;
            w_done      = 1'b0;
            w_clr       = 1'b1;
        end
    end

    sa_wl_delay #(
        .LAT   (MEM_LAT),
        .IDX_W (CNT_W)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_vld   (w_mem_re),
        .i_idx   (r_cnt),
        .o_vld   (w_wvld),
        .o_idx   (w_widx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bank <= '0;
        end else begin
            for (int k = 0; k < N_WEIGHTS; k++) begin
                if (w_wvld && (w_widx == CNT_W'(k))) begin
                    r_bank[k*DATA_W +: DATA_W] <= mem_rdata;
                end
            end
        end
    end

    assign cnt           = r_cnt;
    assign mem_re        = w_mem_re;
    assign w_valid       = w_wvld;
    assign w_idx         = w_widx;
    assign w_bank        = r_bank;
    assign busy          = (r_state != S_IDLE);
    assign done          = w_done;
    assign weights_ready = r_ready;

endmodule

// File: tb/tb_sa_weight_loader.sv
// Directed scoreboard bench for sa_weight_loader with MEM_LAT=1 and MEM_LAT=3
// instances; abort stimulus is added when SA_WL_ABORT_EN is defined.
module tb_sa_weight_loader;

    typedef struct {
        int c;
        int idx;
    } wexp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
`ifdef SA_WL_ABORT_EN
    logic        abort1 = 1'b0;
    logic        abort3 = 1'b0;
`endif
    logic [3:0]  cnt1, cnt3, w_idx1, w_idx3;
    logic        mem_re1, mem_re3, w_valid1, w_valid3;
    logic        busy1, busy3, done1, done3, ready1, ready3;
    logic [7:0]  mem_rdata1, mem_rdata3;
    logic [71:0] w_bank1, w_bank3;
    logic [7:0]  base1 = 8'd0;
    logic [7:0]  base3 = 8'd0;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int re_cnt1 = 0;
    wexp_t q1[$];
    wexp_t q3[$];
    int qd1[$];
    int qd3[$];
    wexp_t e1, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_weight_loader #(.DATA_W(8), .N_WEIGHTS(9), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
`ifdef SA_WL_ABORT_EN
        .abort(abort1),
`endif
        .cnt(cnt1), .mem_re(mem_re1), .mem_rdata(mem_rdata1), .w_valid(w_valid1),
        .w_idx(w_idx1), .w_bank(w_bank1), .busy(busy1), .done(done1),
        .weights_ready(ready1)
    );

    sa_weight_loader #(.DATA_W(8), .N_WEIGHTS(9), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3),
`ifdef SA_WL_ABORT_EN
        .abort(abort3),
`endif
        .cnt(cnt3), .mem_re(mem_re3), .mem_rdata(mem_rdata3), .w_valid(w_valid3),
        .w_idx(w_idx3), .w_bank(w_bank3), .busy(busy3), .done(done3),
        .weights_ready(ready3)
    );

    // Weight memories: data = base + address, garbage when no read is returning.
    logic       m1_v;
    logic [3:0] m1_a;
    logic [2:0] m3_v;
    logic [3:0] m3_a [3];
    always @(posedge clk) begin
        m1_v    <= mem_re1;
        m1_a    <= cnt1;
        m3_v    <= {m3_v[1:0], mem_re3};
        m3_a[0] <= cnt3;
        m3_a[1] <= m3_a[0];
        m3_a[2] <= m3_a[1];
    end
    assign mem_rdata1 = m1_v ? base1 + {4'b0, m1_a} : 8'hEE;
    assign mem_rdata3 = m3_v[2] ? base3 + {4'b0, m3_a[2]} : 8'hEE;

    always @(negedge clk) if (mem_re1) re_cnt1++;

    always @(negedge clk) begin
        if (w_valid1) begin
            n_tests++;
            assert (q1.size() != 0) else begin
                n_fail++;
                $error("FAIL wv1_unexpected observed cyc=%0d idx=%0d expected none", cyc, w_idx1);
            end
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                n_tests++;
                assert (cyc === e1.c && int'(w_idx1) === e1.idx) else begin
                    n_fail++;
                    $error("FAIL wv1 observed cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cyc, w_idx1, e1.c, e1.idx);
                end
            end
        end
        if (done1) begin
            n_tests++;
            assert (qd1.size() != 0 && qd1[0] == cyc) else begin
                n_fail++;
                $error("FAIL done1 observed cyc=%0d expected cyc=%0d", cyc, (qd1.size() != 0) ? qd1[0] : -1);
            end
            if (qd1.size() != 0) void'(qd1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (w_valid3) begin
            n_tests++;
            assert (q3.size() != 0) else begin
                n_fail++;
                $error("FAIL wv3_unexpected observed cyc=%0d idx=%0d expected none", cyc, w_idx3);
            end
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                n_tests++;
                assert (cyc === e3.c && int'(w_idx3) === e3.idx) else begin
                    n_fail++;
                    $error("FAIL wv3 observed cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cyc, w_idx3, e3.c, e3.idx);
                end
            end
        end
        if (done3) begin
            n_tests++;
            assert (qd3.size() != 0 && qd3[0] == cyc) else begin
                n_fail++;
                $error("FAIL done3 observed cyc=%0d expected cyc=%0d", cyc, (qd3.size() != 0) ? qd3[0] : -1);
            end
            if (qd3.size() != 0) void'(qd3.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Load accepted at edge t: w_valid for k after edge t+k+LAT, done after edge t+9+LAT.
    task automatic push1(input int t);
        for (int k = 0; k < 9; k++) q1.push_back('{t + k + 1, k});
        qd1.push_back(t + 10);
    endtask

    task automatic start_load1(input logic [7:0] base, output int t);
        base1 = base;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start1 = 1'b0;
        push1(t);
        @(negedge clk);
    endtask

    task automatic chk_bank1(input string tag, input logic [7:0] base, input int n_new);
        for (int k = 0; k < 9; k++)
            chk(tag, w_bank1[k*8 +: 8], (k < n_new) ? base + 8'(k) : 8'h00);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, t2, re0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", cnt1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ready", ready1, 0);
        chk("rst_bank", w_bank1, 0);
        chk("rst_busy3", busy3, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single load, MEM_LAT=1, data = 10 + address
        start_load1(8'd10, t);
        for (int k = 0; k < 9; k++) begin
            wait_cyc(t + k);
            chk("s1_cnt", cnt1, k);
            chk("s1_re", mem_re1, 1);
        end
        wait_cyc(t + 10);
        chk("s1_done_ready", ready1, 1);
        chk("s1_done_busy", busy1, 1);
        chk("s1_done_re", mem_re1, 0);
        wait_cyc(t + 11);
        chk("s1_idle_busy", busy1, 0);
        chk("s1_idle_cnt", cnt1, 0);
        chk("s1_idle_re", mem_re1, 0);
        chk("s1_idle_ready", ready1, 1);
        chk_bank1("s1_bank", 8'd10, 9);

        // Start held 20 edges: two loads, DONE-cycle start ignored, second load replaces bank
        repeat (2) @(negedge clk);
        re0 = re_cnt1;
        base1 = 8'h40;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        t2 = t + 12;
        push1(t);
        push1(t2);
        @(negedge clk);
        wait_cyc(t + 10);
        chk("s2_ready1", ready1, 1);
        chk_bank1("s2_bank1", 8'h40, 9);
        wait_cyc(t + 11);
        base1 = 8'h80;
        wait_cyc(t2);
        chk("s2_busy2", busy1, 1);
        chk("s2_ready_low_start", ready1, 0);
        wait_cyc(t2 + 9);
        chk("s2_ready_low_drain", ready1, 0);
        wait_cyc(t + 19);
        start1 = 1'b0;
        wait_cyc(t2 + 10);
        chk("s2_ready2", ready1, 1);
        chk_bank1("s2_bank2", 8'h80, 9);
        wait_cyc(t2 + 14);
        chk("s2_reads", re_cnt1 - re0, 18);
        chk("s2_idle", busy1, 0);

        // Reset at cnt=4
        start_load1(8'h20, t);
        wait_cyc(t + 4);
        chk("s3_cnt4", cnt1, 4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        q1.delete();
        qd1.delete();
        @(negedge clk);
        chk("s3_cnt", cnt1, 0);
        chk("s3_re", mem_re1, 0);
        chk("s3_wv", w_valid1, 0);
        chk("s3_widx", w_idx1, 0);
        chk("s3_bank", w_bank1, 0);
        chk("s3_busy", busy1, 0);
        chk("s3_done", done1, 0);
        chk("s3_ready", ready1, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s3_quiet_wv", w_valid1, 0);
        end

        // MEM_LAT=3 load
        base3 = 8'h50;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start3 = 1'b0;
        for (int k = 0; k < 9; k++) q3.push_back('{t + k + 3, k});
        qd3.push_back(t + 12);
        @(negedge clk);
        wait_cyc(t + 10);
        chk("s4_drain_re", mem_re3, 0);
        chk("s4_drain_busy", busy3, 1);
        wait_cyc(t + 12);
        chk("s4_done_wv", w_valid3, 0);
        chk("s4_done_ready", ready3, 1);
        for (int k = 0; k < 9; k++) chk("s4_bank", w_bank3[k*8 +: 8], 8'h50 + 8'(k));
        wait_cyc(t + 16);

`ifdef SA_WL_ABORT_EN
        // Abort at cnt=5 keeps slots 0..4 and suppresses done
        start_load1(8'h30, t);
        wait_cyc(t + 5);
        chk("s5_cnt5", cnt1, 5);
        abort1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        q1.delete();
        qd1.delete();
        @(negedge clk);
        chk("s5_busy", busy1, 0);
        chk("s5_cnt", cnt1, 0);
        chk("s5_ready", ready1, 0);
        chk_bank1("s5_bank", 8'h30, 5);
        repeat (12) @(negedge clk);
        chk("s5_ready_after", ready1, 0);
        abort1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        abort1 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        chk("s5_abort_prio", busy1, 0);
`endif

        repeat (4) @(negedge clk);
        chk("end_q1_empty", q1.size(), 0);
        chk("end_qd1_empty", qd1.size(), 0);
        chk("end_q3_empty", q3.size(), 0);
        chk("end_qd3_empty", qd3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_weight_loader.md
SA_WEIGHT_LOADER -- requirements
Module: sa_weight_loader

Interface
- REQ-001: The block SHALL have parameter DATA_W, default 8, giving the weight word width in bits.
- REQ-002: The block SHALL have parameter N_WEIGHTS, default 9, giving the weights per load (one 3x3 kernel).
- REQ-003: The block SHALL have parameter MEM_LAT, default 1, range 1..4, giving the weight-memory read latency in cycles.
- REQ-004: The block SHALL use one clock; reset is synchronous and active-low.
- REQ-005: Port clk, input, 1 bit: the single clock.
- REQ-006: Port reset_n, input, 1 bit: synchronous active-low reset.
- REQ-007: Port start, input, 1 bit: load request, sampled in IDLE only.
- REQ-008: Port cnt, output, 4 bits: sequence count, driven to the weight address decoder.
- REQ-009: Port mem_re, output, 1 bit: weight-memory read enable.
- REQ-010: Port mem_rdata, input, DATA_W bits: read data, valid MEM_LAT cycles after mem_re.
- REQ-011: Port w_valid, output, 1 bit: a weight is being written this cycle.
- REQ-012: Port w_idx, output, 4 bits: sequence index of the weight being written.
- REQ-013: Port w_bank, output, N_WEIGHTS*DATA_W bits: weight registers, slot k at bits [k*DATA_W +: DATA_W].
- REQ-014: Port busy, output, 1 bit: high in any state other than IDLE.
- REQ-015: Port done, output, 1 bit: one-cycle pulse at load completion.
- REQ-016: Port weights_ready, output, 1 bit: high from done until the next accepted start.

Function
- REQ-017: The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
- REQ-018: In IDLE, start=1 SHALL move the FSM to FETCH, load cnt=0 and clear weights_ready on the next edge.
- REQ-019: In FETCH, mem_re SHALL be 1 and cnt SHALL increment by 1 per cycle over 0..N_WEIGHTS-1.
- REQ-020: When cnt=N_WEIGHTS-1, FETCH SHALL move to DRAIN; cnt SHALL never exceed N_WEIGHTS-1.
- REQ-021: DRAIN SHALL last exactly MEM_LAT cycles with mem_re=0, then move to DONE.
- REQ-022: DONE SHALL last one cycle with done=1, SHALL set weights_ready, and SHALL then return to IDLE.
- REQ-023: w_valid and w_idx SHALL equal mem_re and cnt delayed by exactly MEM_LAT cycles.
- REQ-024: When w_valid=1, w_bank slot w_idx SHALL capture mem_rdata on that edge; all other slots hold.
- REQ-025: For start sampled at edge T: cnt=k at cycles T+1+k, w_valid for k at T+1+k+MEM_LAT, done at T+N_WEIGHTS+MEM_LAT+1.
- REQ-026: start while busy=1 SHALL be ignored; it is neither queued nor restarts the sequence.
- REQ-027: start sampled in DONE SHALL be ignored; the next load needs start in IDLE.
- REQ-028: In IDLE, cnt SHALL be 0 and mem_re SHALL be 0.
- REQ-029: w_bank SHALL hold its contents between loads and SHALL be overwritten slot by slot during a load.

Reset
- REQ-030: reset_n=0 at an edge SHALL force IDLE and zero cnt, mem_re, w_valid, w_idx, all of w_bank, busy, done and weights_ready.
- REQ-031: Reset mid-load SHALL discard the delay pipeline, so no w_valid appears after reset release without a new start.

Configuration
- REQ-032: Macro SA_WL_ABORT_EN SHALL, when defined, add input port abort (1 bit).
- REQ-033: With SA_WL_ABORT_EN, abort=1 in a non-IDLE state SHALL force IDLE on the next edge, zero the delay pipeline, suppress done and leave weights_ready=0.
- REQ-034: With SA_WL_ABORT_EN, w_bank slots already written SHALL keep their values after an abort.
- REQ-035: With SA_WL_ABORT_EN, abort and start in the same IDLE cycle SHALL give abort priority, so the load is not accepted.
- REQ-036: Without SA_WL_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be exactly REQ-017..REQ-031.

Structure
- REQ-037: Shared package sa_pkg SHALL hold the FSM state typedef, the default constants N_WEIGHTS=9, DATA_W=8 and CNT_W=4.
- REQ-038: One sub-module, sa_wl_delay, SHALL implement the MEM_LAT-stage valid/index delay line with synchronous clear.

Verification
- REQ-039: Scenario: MEM_LAT=1, memory returns data=10+address, one start -> cnt 0..8 in T+1..T+9, nine w_valid pulses, done at T+11, w_bank slot k = mem_rdata sampled at T+2+k.
- REQ-040: Scenario: start held high for 20 cycles -> exactly two loads, each of 9 reads; DONE-cycle start is not counted.
- REQ-041: Scenario: MEM_LAT=3 -> done at T+13; no w_valid after T+12.
- REQ-042: Scenario: reset_n=0 at cnt=4 -> all outputs zero next cycle; w_valid stays 0 for 10 idle cycles.
- REQ-043: Scenario (SA_WL_ABORT_EN): abort at cnt=5 -> IDLE next cycle, no done pulse, weights_ready=0, slots 0..4 retained.
- REQ-044: Scenario: back-to-back loads with different data -> second load fully replaces w_bank; weights_ready low from T+1 until the second done.
